serial_frame_deserializer: RTL and testbench

Receive-side companion to the universal shift register: collects a serial bit stream (the shift register's serial data out, either shift direction) into WIDTH-bit parallel words. Frames are delimited by a start-of-frame strobe. Bits are gated by a bit-enable. Completed words are presented through a double-buffered valid/ready output with overrun and framing-error reporting. Sits between a serial link and any parallel consumer.

---
 rtl/serial_frame_deserializer.sv | 132 +++++++++++++
 tb/tb_serial_frame_deserializer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_deserializer
// Brief    : Collects a framed serial bit stream, MSB- or LSB-first, into
//            WIDTH-bit words behind a valid/ready holding register.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_din,
    input  logic             s_en,
    input  logic             sof,
    input  logic             msb_first,
    output logic [WIDTH-1:0] p_dout,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam int c_CNT_W = $clog2(WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_sh;
    logic [WIDTH-1:0]   w_sh_nxt;
    logic [WIDTH-1:0]   w_shifted;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_dir;
    logic               w_dir_nxt;
    logic               w_dir_use;
    logic               w_complete;
    logic               w_abort;
    logic               w_accept_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sh    <= w_sh_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // A sof bit always shifts in the direction requested on that same edge.
    assign w_dir_use = sof ? msb_first : r_dir;
    assign w_shifted = w_dir_use ? {r_sh[WIDTH-2:0], s_din}
                                 : {s_din, r_sh[WIDTH-1:1]};

    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_complete  = 1'b0;
        w_abort     = 1'b0;
        if (s_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (sof) begin
                        w_dir_nxt   = msb_first;
                        w_sh_nxt    = w_shifted;
                        w_cnt_nxt   = c_CNT_W'(1);
                        w_state_nxt = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    w_sh_nxt = w_shifted;
                    if (sof) begin
                        w_abort   = 1'b1;
                        w_dir_nxt = msb_first;
                        w_cnt_nxt = c_CNT_W'(1);
                    end else if (r_cnt == c_CNT_W'(WIDTH - 1)) begin
                        w_complete  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // The holding register can take a new word if empty or drained this edge.
    assign w_accept_word = !p_valid || p_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_dout    <= '0;
            p_valid   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= w_abort;
            if (w_complete) begin
                if (w_accept_word) begin
                    p_dout  <= w_sh_nxt;
                    p_valid <= 1'b1;
                end
            end else if (p_valid && p_ready) begin
                p_valid <= 1'b0;
            end
            if (w_complete && !w_accept_word) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy = (r_state == ST_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_deserializer
// Brief    : Scoreboard bench for serial_frame_deserializer at WIDTH=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_frame_deserializer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             s_din = 1'b0;
    logic             s_en = 1'b0;
    logic             sof = 1'b0;
    logic             msb_first = 1'b0;
    logic [WIDTH-1:0] p_dout;
    logic             p_valid;
    logic             p_ready = 1'b0;
    logic             busy;
    logic             frame_err;
    logic             overrun;
    logic             ovr_clr = 1'b0;

    int               checks = 0;
    int               failures = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_w;

    serial_frame_deserializer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_din     (s_din),
        .s_en      (s_en),
        .sof       (sof),
        .msb_first (msb_first),
        .p_dout    (p_dout),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;

    // Drive on the falling edge, return 1 time unit after the rising edge.
    task automatic send_bit(input logic din, input logic f, input logic en);
        @(negedge clk);
        s_din = din;
        sof   = f;
        s_en  = en;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        send_bit(1'b0, 1'b0, 1'b0);
    endtask

    // Gap cycles carry s_en=0 with sof=1 and junk data, which must be ignored.
    task automatic send_word(input logic [WIDTH-1:0] w, input logic msb,
                             input logic toggle, input logic rdy_last);
        logic b;
        msb_first = msb;
        for (int i = 0; i < WIDTH; i++) begin
            b = msb ? w[WIDTH-1-i] : w[i];
            if (toggle && i > 0) send_bit(~b, 1'b1, 1'b0);
            if (i == WIDTH - 1 && rdy_last) p_ready = 1'b1;
            send_bit(b, (i == 0), 1'b1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        idle();
        checks++;
        if ({p_dout, p_valid, busy, frame_err, overrun} !== '0) begin
            failures++;
            $display("FAIL reset: dout=%h valid=%b busy=%b ferr=%b ovr=%b required all 0",
                     p_dout, p_valid, busy, frame_err, overrun);
        end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_msb_first();
        logic [WIDTH-1:0] bits;
        bits = 4'b1011;
        p_ready = 1'b1;
        msb_first = 1'b1;
        exp_q.push_back(4'hB);
        for (int i = 0; i < WIDTH; i++) begin
            send_bit(bits[WIDTH-1-i], (i == 0), 1'b1);
            checks++;
            if (busy !== (i < WIDTH - 1)) begin
                failures++;
                $display("FAIL msb_busy[%0d]: got %b required %b", i, busy, (i < WIDTH - 1));
            end
        end
        exp_w = exp_q.pop_front();
        checks++;
        if (p_valid !== 1'b1 || p_dout !== exp_w) begin
            failures++;
            $display("FAIL msb_word: valid=%b dout=%h required 1/%h", p_valid, p_dout, exp_w);
        end
        idle();
        checks++;
        if (p_valid !== 1'b0 || p_dout !== exp_w) begin
            failures++;
            $display("FAIL msb_consume: valid=%b dout=%h required 0/%h", p_valid, p_dout, exp_w);
        end
    endtask

    task automatic test_lsb_first(input logic toggle);
        p_ready = 1'b1;
        exp_q.push_back(4'hD);
        send_word(4'hD, 1'b0, toggle, 1'b0);
        exp_w = exp_q.pop_front();
        checks++;
        if (p_valid !== 1'b1 || p_dout !== exp_w || busy !== 1'b0) begin
            failures++;
            $display("FAIL lsb_word(toggle=%b): valid=%b dout=%h busy=%b required 1/%h/0",
                     toggle, p_valid, p_dout, busy, exp_w);
        end
        idle();
    endtask

    task automatic test_overrun();
        p_ready = 1'b0;
        exp_q.push_back(4'hB);
        send_word(4'hB, 1'b1, 1'b0, 1'b0);
        send_word(4'h3, 1'b1, 1'b0, 1'b0);
        exp_w = exp_q.pop_front();
        checks++;
        if (p_valid !== 1'b1 || p_dout !== exp_w || overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set: valid=%b dout=%h ovr=%b required 1/%h/1",
                     p_valid, p_dout, overrun, exp_w);
        end
        ovr_clr = 1'b1;
        p_ready = 1'b1;
        idle();
        ovr_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0 || p_valid !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clr: ovr=%b valid=%b required 0/0", overrun, p_valid);
        end
    endtask

    task automatic test_simultaneous();
        p_ready = 1'b0;
        exp_q.push_back(4'hB);
        send_word(4'hB, 1'b1, 1'b0, 1'b0);
        exp_w = exp_q.pop_front();
        checks++;
        if (p_valid !== 1'b1 || p_dout !== exp_w) begin
            failures++;
            $display("FAIL simul_pending: valid=%b dout=%h required 1/%h", p_valid, p_dout, exp_w);
        end
        exp_q.push_back(4'h6);
        send_word(4'h6, 1'b1, 1'b0, 1'b1);
        exp_w = exp_q.pop_front();
        checks++;
        if (p_valid !== 1'b1 || p_dout !== exp_w || overrun !== 1'b0) begin
            failures++;
            $display("FAIL simul_word: valid=%b dout=%h ovr=%b required 1/%h/0",
                     p_valid, p_dout, overrun, exp_w);
        end
        idle();
    endtask

    task automatic test_premature_sof();
        logic [WIDTH-1:0] bits;
        bits = 4'b0110;
        p_ready = 1'b1;
        msb_first = 1'b1;
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        checks++;
        if (frame_err !== 1'b0 || p_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre: ferr=%b valid=%b busy=%b required 0/0/1",
                     frame_err, p_valid, busy);
        end
        exp_q.push_back(4'h6);
        for (int i = 0; i < WIDTH; i++) begin
            send_bit(bits[WIDTH-1-i], (i == 0), 1'b1);
            checks++;
            if (frame_err !== (i == 0)) begin
                failures++;
                $display("FAIL abort_ferr[%0d]: got %b required %b", i, frame_err, (i == 0));
            end
            if (i < WIDTH - 1) begin
                checks++;
                if (p_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_noword[%0d]: valid=%b required 0", i, p_valid);
                end
            end
        end
        exp_w = exp_q.pop_front();
        checks++;
        if (p_valid !== 1'b1 || p_dout !== exp_w) begin
            failures++;
            $display("FAIL abort_word: valid=%b dout=%h required 1/%h", p_valid, p_dout, exp_w);
        end
        idle();
    endtask

    task automatic test_reset_mid_frame();
        p_ready = 1'b0;
        send_word(4'hB, 1'b1, 1'b0, 1'b0);
        send_word(4'h3, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        send_bit(1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        checks++;
        if ({p_dout, p_valid, busy, frame_err, overrun} !== '0) begin
            failures++;
            $display("FAIL midrst: dout=%h valid=%b busy=%b ferr=%b ovr=%b required all 0",
                     p_dout, p_valid, busy, frame_err, overrun);
        end
        p_ready = 1'b1;
        exp_q.push_back(4'hA);
        send_word(4'hA, 1'b1, 1'b0, 1'b0);
        exp_w = exp_q.pop_front();
        checks++;
        if (p_valid !== 1'b1 || p_dout !== exp_w) begin
            failures++;
            $display("FAIL midrst_word: valid=%b dout=%h required 1/%h", p_valid, p_dout, exp_w);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] w;
        logic             m;
        p_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            w = WIDTH'($urandom);
            m = 1'($urandom);
            exp_q.push_back(w);
            send_word(w, m, 1'b0, 1'b0);
            exp_w = exp_q.pop_front();
            checks++;
            if (p_valid !== 1'b1 || p_dout !== exp_w || overrun !== 1'b0) begin
                failures++;
                $display("FAIL b2b[%0d] msb=%b: valid=%b dout=%h ovr=%b required 1/%h/0",
                         n, m, p_valid, p_dout, overrun, exp_w);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first(1'b0);
        test_lsb_first(1'b1);
        test_overrun();
        test_simultaneous();
        test_premature_sof();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
